// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM driver with per-channel duty and optional linear fade (LED_PWM_PHASE_EN staggers channel phases).
// Latency: led is registered one clk behind pwm_cnt; duty writes reach the output at the next frame_end.
// Backpressure: cfg_ready is low only on the frame_end cycle (and in reset); otherwise every write is accepted.
module led_pwm_fader #(
    parameter int NUM_CH    = 4,
    parameter int PWM_W     = 8,
    parameter int PRESCALE  = 390,
    parameter int FADE_STEP = 1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [PWM_W-1:0]  cfg_duty,
    input  logic              cfg_fade,
    output logic [NUM_CH-1:0] led,
    output logic              frame_tick,
    output logic              busy
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PWM_W:0]  STEP_X  = (PWM_W+1)'(FADE_STEP);

    logic [PS_W-1:0]   ps_cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic              step_en;
    logic              frame_end;
    logic              ready_q;
    logic              accept;

    logic [PWM_W-1:0]  cur_duty [NUM_CH];
    logic [PWM_W-1:0]  tgt_duty [NUM_CH];
    logic [PWM_W-1:0]  cur_nxt  [NUM_CH];
    logic [NUM_CH-1:0] fade;
    logic [NUM_CH-1:0] led_nxt;
    logic [NUM_CH-1:0] diff_vec;

    logic [PWM_W:0]    c_x;
    logic [PWM_W:0]    t_x;
    logic [PWM_W:0]    d_x;
    logic [PWM_W-1:0]  cmp_cnt;

    assign step_en   = (ps_cnt == PS_LAST);
    assign frame_end = step_en && (pwm_cnt == '1);
    // Blocking writes on frame_end keeps tgt stable while cur samples it.
    assign cfg_ready = ready_q && !frame_end;
    assign accept    = cfg_valid && cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt     <= '0;
            pwm_cnt    <= '0;
            ready_q    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            ready_q    <= 1'b1;
            frame_tick <= frame_end;
            if (step_en) begin
                ps_cnt  <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                ps_cnt  <= ps_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        c_x      = '0;
        t_x      = '0;
        d_x      = '0;
        cmp_cnt  = '0;
        led_nxt  = '0;
        diff_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cur_nxt[i] = cur_duty[i];
            // One extra bit so the distance and the step never wrap.
            c_x = {1'b0, cur_duty[i]};
            t_x = {1'b0, tgt_duty[i]};
            d_x = (t_x > c_x) ? (t_x - c_x) : (c_x - t_x);
            if (!fade[i] || (d_x <= STEP_X))
                cur_nxt[i] = tgt_duty[i];
            else if (t_x > c_x)
                cur_nxt[i] = PWM_W'(c_x + STEP_X);
            else
                cur_nxt[i] = PWM_W'(c_x - STEP_X);

            diff_vec[i] = (cur_duty[i] != tgt_duty[i]);
`ifdef LED_PWM_PHASE_EN
            cmp_cnt = pwm_cnt + PWM_W'(i * ((2 ** PWM_W) / NUM_CH));
`else
            cmp_cnt = pwm_cnt;
`endif
            led_nxt[i] = (cmp_cnt < cur_duty[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cur_duty[i] <= '0;
                tgt_duty[i] <= '0;
            end
            fade <= '0;
            led  <= '0;
            busy <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (frame_end)
                    cur_duty[i] <= cur_nxt[i];
                // Out-of-range channel numbers match no index and are dropped.
                if (accept && (int'(cfg_ch) == i)) begin
                    tgt_duty[i] <= cfg_duty;
                    fade[i]     <= cfg_fade;
                end
            end
            led  <= led_nxt;
            busy <= |diff_vec;
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader: two instances (4ch step 2, 3ch step 1), PWM_W=4, PRESCALE=1.
// Per-frame on-time of every channel is accumulated and compared against hand-computed duties.
module tb_led_pwm_fader;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       cfg_valid_a, cfg_ready_a, cfg_fade_a, tick_a, busy_a;
    logic [1:0] cfg_ch_a;
    logic [3:0] cfg_duty_a;
    logic [3:0] led_a;

    logic       cfg_valid_b, cfg_ready_b, cfg_fade_b, tick_b, busy_b;
    logic [1:0] cfg_ch_b;
    logic [3:0] cfg_duty_b;
    logic [2:0] led_b;

    int n_chk  = 0;
    int n_fail = 0;

    int acc_a  [4];
    int meas_a [4];
    int acc_b  [3];
    int meas_b [3];

    always #5 clk = ~clk;

    led_pwm_fader #(.NUM_CH(4), .PWM_W(4), .PRESCALE(1), .FADE_STEP(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a), .cfg_ch(cfg_ch_a),
        .cfg_duty(cfg_duty_a), .cfg_fade(cfg_fade_a),
        .led(led_a), .frame_tick(tick_a), .busy(busy_a)
    );

    led_pwm_fader #(.NUM_CH(3), .PWM_W(4), .PRESCALE(1), .FADE_STEP(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .cfg_ch(cfg_ch_b),
        .cfg_duty(cfg_duty_b), .cfg_fade(cfg_fade_b),
        .led(led_b), .frame_tick(tick_b), .busy(busy_b)
    );

    // The frame_tick cycle still shows the last step of the frame that just ended.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                acc_a[i]  = 0;
                meas_a[i] = 0;
            end else if (tick_a) begin
                meas_a[i] = acc_a[i] + int'(led_a[i]);
                acc_a[i]  = 0;
            end else begin
                acc_a[i]  = acc_a[i] + int'(led_a[i]);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                acc_b[i]  = 0;
                meas_b[i] = 0;
            end else if (tick_b) begin
                meas_b[i] = acc_b[i] + int'(led_b[i]);
                acc_b[i]  = 0;
            end else begin
                acc_b[i]  = acc_b[i] + int'(led_b[i]);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_tick(input bit sel);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel ? tick_b : tick_a) == 1'b0) && (n < 64));
        check_eq("tick_seen", 32'(sel ? tick_b : tick_a), 1);
        #1;
    endtask

    task automatic cfg_wr(input bit sel, input int ch, input int duty, input bit fd);
        int n;
        @(negedge clk);
        if (sel) begin
            cfg_valid_b = 1'b1; cfg_ch_b = 2'(ch); cfg_duty_b = 4'(duty); cfg_fade_b = fd;
        end else begin
            cfg_valid_a = 1'b1; cfg_ch_a = 2'(ch); cfg_duty_a = 4'(duty); cfg_fade_a = fd;
        end
        n = 0;
        while (((sel ? cfg_ready_b : cfg_ready_a) == 1'b0) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        check_eq("wr_ready", 32'(sel ? cfg_ready_b : cfg_ready_a), 1);
        @(posedge clk);
        #1;
        cfg_valid_a = 1'b0;
        cfg_valid_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int duties [3];
        logic [3:0] exp_led;
        duties = '{5, 0, 15};

        rst_n = 1'b0;
        cfg_valid_a = 1'b0; cfg_ch_a = '0; cfg_duty_a = '0; cfg_fade_a = 1'b0;
        cfg_valid_b = 1'b0; cfg_ch_b = '0; cfg_duty_b = '0; cfg_fade_b = 1'b0;

        // Reset state and release.
        repeat (3) @(negedge clk);
        check_eq("rst_led", 32'(led_a), 0);
        check_eq("rst_tick", 32'(tick_a), 0);
        check_eq("rst_busy", 32'(busy_a), 0);
        check_eq("rst_ready", 32'(cfg_ready_a), 0);
        rst_n = 1'b1;
        #1;
        check_eq("ready_before_edge", 32'(cfg_ready_a), 0);
        @(negedge clk);
        check_eq("ready_after_rst_a", 32'(cfg_ready_a), 1);
        check_eq("ready_after_rst_b", 32'(cfg_ready_b), 1);

        // Frame length: 16 steps of one clk each.
        wait_tick(0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_a && n < 64);
        check_eq("frame_len", n, 16);

        // Immediate duty changes on ch0.
        for (int k = 0; k < 3; k++) begin
            wait_tick(0);
            cfg_wr(0, 0, duties[k], 1'b0);
            wait_tick(0);
            wait_tick(0);
            check_eq("imm_duty", meas_a[0], duties[k]);
        end

        // Fade up then down on ch1 with step 2.
        wait_tick(0);
        cfg_wr(0, 1, 7, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_eq("fade_busy_up", 32'(busy_a), 1);
        wait_tick(0);
        check_eq("fade_old", meas_a[1], 0);
        wait_tick(0); check_eq("fade_up0", meas_a[1], 2);
        wait_tick(0); check_eq("fade_up1", meas_a[1], 4);
        wait_tick(0); check_eq("fade_up2", meas_a[1], 6);
        check_eq("busy_last_step", 32'(busy_a), 1);
        @(negedge clk);
        check_eq("busy_fall", 32'(busy_a), 0);
        wait_tick(0); check_eq("fade_up3", meas_a[1], 7);
        cfg_wr(0, 1, 0, 1'b1);
        wait_tick(0); check_eq("fade_dn_old", meas_a[1], 7);
        wait_tick(0); check_eq("fade_dn0", meas_a[1], 5);
        wait_tick(0); check_eq("fade_dn1", meas_a[1], 3);
        wait_tick(0); check_eq("fade_dn2", meas_a[1], 1);
        wait_tick(0); check_eq("fade_dn3", meas_a[1], 0);

        // Write presented on the frame_end cycle is held off by one clk (ch0 sits at 15).
        wait_tick(0);
        repeat (15) @(negedge clk);
        check_eq("fe_ready", 32'(cfg_ready_a), 0);
        check_eq("fe_busy", 32'(busy_a), 0);
        cfg_valid_a = 1'b1; cfg_ch_a = 2'd0; cfg_duty_a = 4'd9; cfg_fade_a = 1'b0;
        @(negedge clk);
        check_eq("fe_tick", 32'(tick_a), 1);
        check_eq("fe_ready_next", 32'(cfg_ready_a), 1);
        check_eq("fe_busy_next", 32'(busy_a), 0);
        @(posedge clk);
        #1;
        cfg_valid_a = 1'b0;
        @(negedge clk);
        check_eq("fe_not_written_early", 32'(busy_a), 0);
        @(negedge clk);
        check_eq("fe_written_late", 32'(busy_a), 1);
        wait_tick(0); check_eq("fe_old_duty", meas_a[0], 15);
        wait_tick(0); check_eq("fe_new_duty", meas_a[0], 9);

        // Out-of-range channel on the 3-channel instance.
        wait_tick(1);
        cfg_wr(1, 3, 10, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_eq("oor_busy", 32'(busy_b), 0);
        wait_tick(1);
        wait_tick(1);
        for (int i = 0; i < 3; i++) check_eq("oor_duty", meas_b[i], 0);

        // Retarget mid-fade on ch2 with step 1.
        wait_tick(1);
        cfg_wr(1, 2, 12, 1'b1);
        for (int k = 0; k < 8; k++) begin
            wait_tick(1);
            check_eq("ramp_up", meas_b[2], k);
        end
        cfg_wr(1, 2, 3, 1'b1);
        for (int k = 0; k < 6; k++) begin
            wait_tick(1);
            check_eq("retarget", meas_b[2], 8 - k);
        end
        check_eq("retarget_busy", 32'(busy_b), 0);

        // Edge alignment, all channels duty 4.
        wait_tick(0);
        for (int i = 0; i < 4; i++) cfg_wr(0, i, 4, 1'b0);
        wait_tick(0);
        wait_tick(0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
`ifdef LED_PWM_PHASE_EN
                exp_led[i] = (((k + 4 * i) % 16) < 4);
`else
                exp_led[i] = (k < 4);
`endif
            end
            check_eq("phase_led", 32'(led_a), 32'(exp_led));
        end

        // Reset in the middle of a fade.
        wait_tick(1);
        cfg_wr(1, 0, 15, 1'b1);
        wait_tick(1);
        wait_tick(1);
        wait_tick(1);
        @(negedge clk);
        check_eq("pre_rst_led", 32'(led_b[0]), 1);
        check_eq("pre_rst_busy", 32'(busy_b), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_led_b", 32'(led_b), 0);
        check_eq("async_led_a", 32'(led_a), 0);
        check_eq("async_busy", 32'(busy_b), 0);
        check_eq("async_ready", 32'(cfg_ready_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(1);
        wait_tick(1);
        check_eq("post_rst_duty", meas_b[0], 0);
        check_eq("post_rst_busy", 32'(busy_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
